// File: rtl/mult_pkg.sv
`default_nettype none
// mult_pkg: shared types and elaboration helpers for the radix-4 Booth multiplier.
// Rev 1.0
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    SUB1 = 3'd3,
    SUB2 = 3'd4
  } booth_op_t;

  function automatic bit width_ok(input int w);
    return (w >= 4) && ((w % 2) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_recode.sv
`default_nettype none
// booth_recode: maps the radix-4 Booth window {mplr[1:0], extra} to an add/sub operation.
// Rev 1.0
module booth_recode
  import mult_pkg::*;
(
  input  logic [2:0] bits,
  output booth_op_t  op
);

  always_comb begin
    op = NOP;
    case (bits)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mult_booth_seq.sv
`default_nettype none
// mult_booth_seq: sequential radix-4 Booth multiplier, signed/unsigned, start/busy handshake.
// Rev 1.0
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam int XW   = WIDTH + 2;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("mult_booth_seq: WIDTH must be even and at least 4");
  end

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [XW-1:0]      acc, mplr, mcand;
  logic               extra, mode;
  logic               launch, last;
  booth_op_t          op;
  logic [XW-1:0]      addend, sum;
  logic               cin;
  logic [2*XW-1:0]    pair_nxt;
  logic [WIDTH-1:0]   prod_hi, prod_lo;
  logic               overflow;

  assign last = (cnt == CW'(ITER - 1));

  always_comb begin
    state_nxt      = state;
    launch         = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        if (start) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  booth_recode u_recode (
    .bits ({mplr[1:0], extra}),
    .op   (op)
  );

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (op)
      ADD1: addend = mcand;
      ADD2: addend = {mcand[XW-2:0], 1'b0};
      SUB1: begin
        addend = ~mcand;
        cin    = 1'b1;
      end
      SUB2: begin
        addend = ~{mcand[XW-2:0], 1'b0};
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
  end

  // Two guard bits make +-2M fit and keep the running sum exact for both modes.
  assign sum      = acc + addend + XW'(cin);
  assign pair_nxt = {{2{sum[XW-1]}}, sum, mplr[XW-1:2]};
  assign prod_lo  = pair_nxt[WIDTH-1:0];
  assign prod_hi  = pair_nxt[2*WIDTH-1:WIDTH];
  assign overflow = mode ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}}) : (prod_hi != '0);

  always_ff @(posedge clock) begin
    if (!clr) begin
      cnt            <= '0;
      acc            <= '0;
      mplr           <= '0;
      mcand          <= '0;
      extra          <= 1'b0;
      mode           <= 1'b0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
    end else if (launch) begin
      cnt   <= '0;
      acc   <= '0;
      mplr  <= {{2{signed_mode & data_operandB[WIDTH-1]}}, data_operandB};
      mcand <= {{2{signed_mode & data_operandA[WIDTH-1]}}, data_operandA};
      extra <= 1'b0;
      mode  <= signed_mode;
    end else if (state == RUN) begin
      cnt   <= cnt + CW'(1);
      acc   <= pair_nxt[2*XW-1:XW];
      mplr  <= pair_nxt[XW-1:0];
      extra <= mplr[1];
      if (last) begin
        data_result    <= prod_lo;
        data_result_hi <= prod_hi;
        data_exception <= overflow;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_booth_seq.sv
`default_nettype none
// tb_mult_booth_seq: self-checking bench for mult_booth_seq (WIDTH=32 and WIDTH=8 instances).
module tb_mult_booth_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start_s [2];
  logic        mode_s  [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];

  logic        busy32, rdy32, exc32, busy8, rdy8, exc8;
  logic [31:0] lo32, hi32;
  logic [7:0]  lo8, hi8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  // Reference model state: cycles left in the current operation and the visible outputs.
  int          left     [2];
  bit          m_rdy    [2];
  logic [63:0] m_prod   [2];
  bit          m_exc    [2];
  logic [63:0] pend     [2];
  bit          pend_exc [2];

  always #5 clk = ~clk;

  mult_booth_seq #(.WIDTH(32)) u32 (
    .clock(clk), .clr(clr), .start(start_s[0]), .signed_mode(mode_s[0]),
    .data_operandA(a_s[0]), .data_operandB(b_s[0]),
    .busy(busy32), .data_resultRDY(rdy32), .data_result(lo32),
    .data_result_hi(hi32), .data_exception(exc32)
  );

  mult_booth_seq #(.WIDTH(8)) u8 (
    .clock(clk), .clr(clr), .start(start_s[1]), .signed_mode(mode_s[1]),
    .data_operandA(a_s[1][7:0]), .data_operandB(b_s[1][7:0]),
    .busy(busy8), .data_resultRDY(rdy8), .data_result(lo8),
    .data_result_hi(hi8), .data_exception(exc8)
  );

  function automatic int wid(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] wmask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
    longint      sa, sb;
    logic [63:0] p, pm;
    logic [31:0] am, bm;
    am = a & wmask(w);
    bm = b & wmask(w);
    sa = longint'({32'd0, am});
    sb = longint'({32'd0, bm});
    if (s && am[w-1]) sa = sa - (longint'(1) << w);
    if (s && bm[w-1]) sb = sb - (longint'(1) << w);
    p  = 64'(sa * sb);
    pm = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return p & pm;
  endfunction

  function automatic bit ref_exc(input bit s, input logic [63:0] p, input int w);
    logic [31:0] hi, lo;
    hi = 32'(p >> w) & wmask(w);
    lo = 32'(p) & wmask(w);
    if (s) return hi != (lo[w-1] ? wmask(w) : 32'd0);
    return hi != 32'd0;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy32 : busy8;
  endfunction
  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy32 : rdy8;
  endfunction
  function automatic logic get_exc(input int d);
    return (d == 0) ? exc32 : exc8;
  endfunction
  function automatic logic [63:0] get_prod(input int d);
    return (d == 0) ? {hi32, lo32} : {48'd0, hi8, lo8};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: an accepted start costs WIDTH/2+1 edges, then the result shows for one cycle.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!clr) begin
        left[d]   = 0;
        m_rdy[d]  = 1'b0;
        m_prod[d] = 64'd0;
        m_exc[d]  = 1'b0;
      end else if (left[d] != 0) begin
        left[d]--;
        if (left[d] == 0) begin
          m_rdy[d]  = 1'b1;
          m_prod[d] = pend[d];
          m_exc[d]  = pend_exc[d];
        end
      end else begin
        m_rdy[d] = 1'b0;
        if (start_s[d]) begin
          left[d]     = wid(d) / 2 + 1;
          pend[d]     = ref_prod(mode_s[d], a_s[d], b_s[d], wid(d));
          pend_exc[d] = ref_exc(mode_s[d], pend[d], wid(d));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy[w%0d] cyc%0d", wid(d), cyc), 64'(get_busy(d)), 64'(left[d] != 0));
        chk($sformatf("rdy[w%0d] cyc%0d", wid(d), cyc), 64'(get_rdy(d)), 64'(m_rdy[d]));
        chk($sformatf("prod[w%0d] cyc%0d", wid(d), cyc), get_prod(d), m_prod[d]);
        chk($sformatf("exc[w%0d] cyc%0d", wid(d), cyc), 64'(get_exc(d)), 64'(m_exc[d]));
      end
    end
  end

  task automatic launch(input int d, input bit s, input logic [31:0] a,
                        input logic [31:0] b, output int t0);
    @(negedge clk);
    start_s[d] = 1'b1;
    mode_s[d]  = s;
    a_s[d]     = a;
    b_s[d]     = b;
    @(negedge clk);
    start_s[d] = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_rdy(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (get_rdy(d)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout[w%0d]: got no data_resultRDY, expected one within 60 cycles", wid(d));
    end
  endtask

  task automatic run_lit(input int d, input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input bit exp_e, input string name);
    int t0;
    bit ok;
    launch(d, s, a, b, t0);
    wait_rdy(d, ok);
    if (ok) begin
      chk({name, " latency"}, 64'(cyc - t0), 64'(wid(d) / 2 + 1));
      chk({name, " product"}, get_prod(d), exp_p);
      chk({name, " exception"}, 64'(get_exc(d)), 64'(exp_e));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit ok;
    int seen;
    clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      mode_s[d]  = 1'b0;
      a_s[d]     = 32'd0;
      b_s[d]     = 32'd0;
    end
    @(posedge clk);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy32), 64'd0);
    chk("reset rdy", 64'(rdy32), 64'd0);
    chk("reset product", {hi32, lo32}, 64'd0);
    chk("reset exception", 64'(exc32), 64'd0);
    clr = 1'b1;

    run_lit(0, 1'b1, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, "s 3*-4");
    run_lit(0, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b1, "u ffffffff*2");
    run_lit(0, 1'b1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "s -1*2");
    run_lit(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, "s min*-1");
    run_lit(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, "u max*max");
    run_lit(0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1, "s max*max");
    run_lit(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, "s -1*-1");

    // start during RUN is ignored; start held high in DONE chains the next operation
    launch(0, 1'b1, 32'd7, 32'd9, t0);
    repeat (2) @(negedge clk);
    start_s[0] = 1'b1; a_s[0] = 32'd100; b_s[0] = 32'd100; mode_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (6) @(negedge clk);
    start_s[0] = 1'b1; a_s[0] = 32'h0000_DEAD; b_s[0] = 32'h0000_BEEF;
    @(negedge clk);
    a_s[0] = 32'd5; b_s[0] = 32'd6; mode_s[0] = 1'b1;
    wait_rdy(0, ok);
    if (ok) begin
      chk("ignore-start latency", 64'(cyc - t0), 64'd17);
      chk("ignore-start product", {hi32, lo32}, 64'd63);
    end
    t0 = cyc + 1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_rdy(0, ok);
    if (ok) begin
      chk("chained latency", 64'(cyc - t0), 64'd17);
      chk("chained product", {hi32, lo32}, 64'd30);
    end
    @(negedge clk);

    // reset in the middle of an operation
    launch(0, 1'b0, 32'h1234, 32'h5678, t0);
    repeat (7) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    chk("midrun-clr busy", 64'(busy32), 64'd0);
    chk("midrun-clr rdy", 64'(rdy32), 64'd0);
    chk("midrun-clr product", {hi32, lo32}, 64'd0);
    chk("midrun-clr exception", 64'(exc32), 64'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy32) seen++;
    end
    chk("midrun-clr rdy pulses", 64'(seen), 64'd0);
    run_lit(0, 1'b0, 32'd12, 32'd13, 64'd156, 1'b0, "post-clr 12*13");

    run_lit(1, 1'b1, 32'h80, 32'h80, 64'h4000, 1'b1, "w8 s -128*-128");
    run_lit(1, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 1'b1, "w8 u 255*255");
    run_lit(1, 1'b1, 32'h00, 32'h5A, 64'h0000, 1'b0, "w8 s 0*5a");
    run_lit(1, 1'b0, 32'h00, 32'hFF, 64'h0000, 1'b0, "w8 u 0*ff");
    run_lit(1, 1'b1, 32'hFF, 32'hFF, 64'h0001, 1'b0, "w8 s -1*-1");
    run_lit(1, 1'b1, 32'h7F, 32'hFF, 64'hFF81, 1'b0, "w8 s 127*-1");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Parametrised, sequential radix-4 (modified Booth) multiplier; next generation of the 32-bit iterative multiplier in the multdiv unit.
- Adds the following:
  - generic WIDTH;
  - a per-operation signed/unsigned mode;
  - an explicit start/busy handshake;
  - a registered full 2*WIDTH product;
  - mode-aware overflow.
- Sits beside the divider in multdiv; the pipeline stalls on busy and captures the product on data_resultRDY.

Parameters:
- WIDTH, 32, operand width; must be even and at least 4.
- ITER, WIDTH/2+1, Booth iterations. Derived; do not override.
- CW, $clog2(ITER+1), iteration counter width. Derived.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-low reset; clr=0 at a rising edge resets the block.
- start  in  1  request; sampled only in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement operands; 0 = unsigned. Latched with start.
- data_operandA  in  WIDTH  multiplicand. Latched with start.
- data_operandB  in  WIDTH  multiplier. Latched with start.
- busy  out  1  high while in RUN.
- data_resultRDY  out  1  one-cycle pulse when the result is valid.
- data_result  out  WIDTH  low WIDTH bits of the product.
- data_result_hi  out  WIDTH  high WIDTH bits of the product.
- data_exception  out  1  product does not fit in WIDTH bits for the latched mode.

Behaviour:
- Reset (clr=0 at an edge, any state, including mid-operation):
  - state goes to IDLE and the counter to 0;
  - busy, data_resultRDY, data_exception, data_result and data_result_hi all go to 0;
  - any in-flight operation is discarded.
- State machine:
  - IDLE, start=1: latch operands and mode, go to RUN, counter=0.
  - IDLE, start=0: stay in IDLE.
  - RUN: one iteration per edge; counter increments; start is ignored.
  - RUN, counter==ITER-1 at the edge: go to DONE and write the outputs.
  - DONE: data_resultRDY=1 for exactly this cycle.
    - start=1: behaves as from IDLE (back-to-back operation allowed).
    - start=0: go to IDLE.
- Outputs hold their last value in IDLE and RUN until the next result is written.
- Latency:
  - start sampled at edge E0; result visible after edge E0+ITER.
  - ITER=17 for WIDTH=32.
  - Throughput is one result per ITER+1 cycles when start is held high.
- Datapath:
  - Operands are extended to WIDTH+2 bits: sign-extended if signed_mode, else zero-extended.
  - The accumulator is WIDTH+2 bits wide.
  - Product register {acc, mplr, extra}; extra is initialised to 0.
  - Each iteration decodes {mplr[1:0], extra} as follows:
    - 000 and 111: nop;
    - 001 and 010: +M;
    - 011: +2M;
    - 100: -2M;
    - 101 and 110: -M.
  - After each iteration: arithmetic shift right by 2 of the {acc, mplr} pair; extra <= mplr[1] (taken before the shift).
  - Subtraction is add of the complement with carry-in 1, at WIDTH+2 bits, with no internal overflow trap.
- Result: the 2*WIDTH product is the low 2*WIDTH bits of {acc, mplr} after ITER iterations. It is exact for all inputs in both modes.
- data_exception:
  - signed_mode=1: 1 unless data_result_hi is all copies of data_result[WIDTH-1].
  - signed_mode=0: 1 if data_result_hi != 0.
- A change of operands or signed_mode during RUN has no effect.

Decomposition:
- Package mult_pkg holds:
  - state typedef {IDLE, RUN, DONE};
  - Booth op typedef {NOP, ADD1, ADD2, SUB1, SUB2};
  - a width-check constant function (WIDTH even, ≥4).
- One sub-module, booth_recode: combinational {mplr[1:0], extra} -> op.
- The FSM, counter and datapath stay in mult_booth_seq.

Test Plan:
- WIDTH=32, signed, A=3, B=-4, start pulse -> busy for 17 cycles; data_resultRDY pulse after edge E0+17; {hi,lo}=0xFFFFFFFF_FFFFFFF4; exception=0.
- WIDTH=32, unsigned, A=0xFFFFFFFF, B=2 -> {hi,lo}=0x00000001_FFFFFFFE; exception=1. Same operands signed (-1*2) -> 0xFFFFFFFF_FFFFFFFE; exception=0.
- WIDTH=32, signed, A=0x80000000, B=0xFFFFFFFF -> {hi,lo}=0x00000000_80000000; exception=1.
- Start re-asserted at cycles 3 and 10 of RUN with new operands -> ignored; original product delivered at E0+17; start held high in DONE launches the next operation.
- clr=0 at cycle 8 of RUN -> next cycle state IDLE; all outputs 0; no data_resultRDY pulse; a new start completes normally.
- WIDTH=8 instance, ITER=5:
  - signed -128*-128 -> {hi,lo}=0x4000, exception=1;
  - unsigned 255*255 -> 0xFE01, exception=1;
  - 0*anything -> 0, exception=0.
